// File: rtl/bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first,
// one full-adder cell with b inverted and carry-in forced to 1.
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;

  logic             w_nb;
  logic             w_s;
  logic             w_cnew;
  logic             w_last;
  logic             w_load;

  assign w_nb   = ~r_b[0];
  assign w_s    = r_a[0] ^ w_nb ^ r_carry;
  assign w_cnew = (r_a[0] & w_nb) | (r_a[0] & r_carry)
                | (w_nb & r_carry);
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  assign w_load = start && (r_state != SHIFT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? SHIFT : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= 1'b1;
      r_cnt   <= '0;
    end else if (r_state == SHIFT) begin
      r_a     <= r_a >> 1;
      r_b     <= r_b >> 1;
      r_res   <= {w_s, r_res[WIDTH-1:1]};
      r_carry <= w_cnew;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  // Result outputs load only on the final SHIFT edge, so they hold
  // steady through any following operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (r_state == SHIFT && w_last) begin
      r_diff   <= {w_s, r_res[WIDTH-1:1]};
      r_borrow <= ~w_cnew;
      r_ovf    <= r_carry ^ w_cnew;
    end
  end

  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign overflow   = r_ovf;

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Self-checking bench for bit_serial_subtractor (WIDTH = 8):
// directed table, random vs. arithmetic model, multi-cycle corners.
module tb_bit_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       borrow_out;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;

  bit_serial_subtractor #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .busy(busy), .done(done),
    .diff(diff), .borrow_out(borrow_out),
    .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] d;
    logic       br;
    logic       ov;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && busy && done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL busy_done_overlap: got 1 want 0");
    end
  end

  function automatic void model(input logic [7:0] x,
                                input logic [7:0] y,
                                output logic [7:0] d,
                                output logic br,
                                output logic ov);
    int sx;
    int sy;
    int sd;
    sx = $signed(x);
    sy = $signed(y);
    sd = sx - sy;
    d  = 8'(int'(x) - int'(y));
    br = (int'(x) < int'(y));
    ov = (sd < -128) || (sd > 127);
  endfunction

  // Returns at the negedge following the accepting edge.
  task automatic start_op(input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
    a     = 8'hxx;
    b     = 8'hxx;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got 0 want 1");
    end
  endtask

  task automatic run_check(input string nm,
                           input logic [7:0] x,
                           input logic [7:0] y,
                           input logic [7:0] d,
                           input logic br,
                           input logic ov);
    int n;
    start_op(x, y);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    wait_done(n);
    chk({nm, "_lat"}, 32'(n), 32'd8);
    chk({nm, "_diff"}, 32'(diff), 32'(d));
    chk({nm, "_borrow"}, 32'(borrow_out), 32'(br));
    chk({nm, "_ovf"}, 32'(overflow), 32'(ov));
  endtask

  vec_t tbl[5];

  initial begin
    int         n;
    int         seen;
    logic [7:0] md;
    logic       mbr;
    logic       mov;
    logic [7:0] rx;
    logic [7:0] ry;

    tbl[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    tbl[4] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    a     = 8'h00;
    b     = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_check($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b,
                tbl[i].d, tbl[i].br, tbl[i].ov);
      @(negedge clk);
      chk($sformatf("tbl%0d_pulse", i), 32'(done), 32'd0);
    end

    for (int i = 0; i < 24; i++) begin
      rx = 8'($urandom);
      ry = 8'($urandom);
      if (i == 0) ry = rx;
      model(rx, ry, md, mbr, mov);
      run_check($sformatf("rnd%0d", i), rx, ry, md, mbr, mov);
    end

    // Start while busy must be ignored.
    start_op(8'h10, 8'h01);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(n);
    chk("ign_diff", 32'(diff), 32'h0F);
    chk("ign_borrow", 32'(borrow_out), 32'd0);
    chk("ign_ovf", 32'(overflow), 32'd0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("ign_no_second", 32'(seen), 32'd0);

    // Reset in the 4th SHIFT cycle aborts.
    start_op(8'h20, 8'h10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow_out), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    run_check("restart", 8'h09, 8'h0A, 8'hFF, 1'b1, 1'b0);

    // Back-to-back: start during the DONE cycle.
    start_op(8'h33, 8'h11);
    wait_done(n);
    chk("b2b_first", 32'(diff), 32'h22);
    start = 1'b1;
    a     = 8'h40;
    b     = 8'h20;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    n    = 1;
    seen = 0;
    while (!done && n < 40) begin
      if (diff !== 8'h22) seen++;
      @(negedge clk);
      n++;
    end
    chk("b2b_hold", 32'(seen), 32'd0);
    chk("b2b_done", 32'(done), 32'd1);
    chk("b2b_period", 32'(n), 32'd9);
    chk("b2b_diff", 32'(diff), 32'h20);
    chk("b2b_borrow", 32'(borrow_out), 32'd0);
    chk("b2b_ovf", 32'(overflow), 32'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bit_serial_subtractor.md
# bit_serial_subtractor

Sequential two's-complement subtractor. Computes diff = a − b one bit per clock, LSB first. It uses a single full-adder cell with b inverted and the initial carry forced to 1. Sits beside the combinational Full_Adder datapath as the area-minimal, multi-cycle inverse operation. Driven by a start/busy/done handshake from the lab's top-level ALU controller.

## Interface
- WIDTH, 8, operand and result width in bits (≥ 2).

- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising clk; accepted only when busy = 0.
- a  input  WIDTH  minuend; sampled on the accepting edge only.
- b  input  WIDTH  subtrahend; sampled on the accepting edge only.
- busy  output  1  high while a subtraction is in progress.
- done  output  1  single-cycle pulse: diff/borrow_out/overflow valid.
- diff  output  WIDTH  a − b modulo 2^WIDTH.
- borrow_out  output  1  1 when unsigned a < b.
- overflow  output  1  1 when signed a − b is not representable in WIDTH bits.

## Operation
- States: IDLE, SHIFT, DONE. Reset state IDLE.
- IDLE: busy = 0, done = 0.
  - start = 1 latches a into shift register A and b into shift register B.
  - Sets carry = 1 and bit counter = 0; next state SHIFT.
- SHIFT: busy = 1. Each cycle:
  - s = A[0] ^ ~B[0] ^ carry.
  - carry ← majority(A[0], ~B[0], carry).
  - s shifts into the result register from the MSB side; A and B shift right.
  - Counter increments.
  - When counter = WIDTH−1, the cycle also records carry-into-MSB (the carry before the update). Next state DONE.
- DONE: busy = 0, done = 1 for exactly one cycle.
  - diff = result register.
  - borrow_out = ~carry (final carry-out).
  - overflow = carry-into-MSB ^ carry-out.
  - Next state IDLE, or SHIFT if start = 1 in this cycle (new operands latched).
- diff, borrow_out and overflow hold their last values until the next DONE.
  - They do not change during a subsequent SHIFT phase: the result register is separate from the output register, which loads on SHIFT→DONE.
- start while busy = 1 is ignored; operands are not resampled.
- Arithmetic is purely modular. No saturation.

## Timing
- Reset (rst_n low, asynchronous, any state): state IDLE; busy, done, diff, borrow_out, overflow all 0; internal registers and counter cleared.
- Reset mid-SHIFT aborts the operation. No done pulse is produced.
- Latency: start accepted at edge E0 → busy high after E0 → SHIFT occupies edges E1..E_WIDTH → done high after edge E_WIDTH for one cycle.
  - done and result outputs are valid WIDTH+1 cycles after the accepting edge is counted as 0, i.e. in cycle WIDTH+1.
- Throughput: back-to-back start in the DONE cycle gives one result every WIDTH+1 cycles.
- busy and done are never high simultaneously.

## Test plan
- WIDTH = 8, reset: rst_n low for 2 cycles → all outputs 0, busy 0. Then a = 0x05, b = 0x03, start pulse → busy for 8 cycles, done in cycle 9 with diff = 0x02, borrow_out = 0, overflow = 0.
- a = 0x03, b = 0x05 → diff = 0xFE, borrow_out = 1, overflow = 0. Also a = 0x00, b = 0x00 → diff = 0x00, borrow_out = 0, overflow = 0.
- a = 0x80, b = 0x01 → diff = 0x7F, borrow_out = 0, overflow = 1. Also a = 0x7F, b = 0xFF → diff = 0x80, borrow_out = 1, overflow = 1.
- a = 0x10, b = 0x01, start; 3 cycles later start again with a = 0xFF, b = 0xFF → second start ignored; done gives diff = 0x0F, borrow 0, overflow 0.
- Start a = 0x20, b = 0x10; assert rst_n low at 4th SHIFT cycle → busy and all outputs 0 immediately, no done. Restart a = 0x09, b = 0x0A → diff = 0xFF, borrow_out = 1, overflow = 0.
- Start asserted during the DONE cycle with a = 0x40, b = 0x20 → busy rises the next cycle. First result stays stable on diff until the second done (diff = 0x20), 9 cycles later.
